// File: rtl/regfile_pkg.sv
// Shared register-file definitions: widths, register count, the hardwired
// zero register index, address/data types and the dump reader state encoding.
package regfile_pkg;

   localparam int unsigned REG_DATA_W = 64;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 32;
   localparam int unsigned ZERO_REG   = 31;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_DATA_W-1:0] reg_data_t;

   // Explicit 3-bit encoding keeps state values stable for waveform/debug tools.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      READ = 3'd2,
      SEND = 3'd3,
      DONE = 3'd4
   } dump_state_t;

   // Number of beats a dump over [first, last] produces.
   function automatic int unsigned dump_beats(input int unsigned first,
                                              input int unsigned last);
      return last - first + 1;
   endfunction

endpackage : regfile_pkg

// File: rtl/regfile_dump_reader_stream_hold_reg.sv
// Single-entry output holding register for the dump stream.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   load              capture in_data/in_idx/in_last and raise valid
//   accept            downstream took the beat; drop valid
//   in_data/in_idx/in_last   beat payload to capture
//   valid/data/idx/last      registered beat presented downstream
// The payload only changes on load, so it stays stable under backpressure.
module stream_hold_reg #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              accept,
   input  logic [DATA_W-1:0] in_data,
   input  logic [ADDR_W-1:0] in_idx,
   input  logic              in_last,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [ADDR_W-1:0] idx,
   output logic              last
);

   // Load wins over accept; the controller never asserts both together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
         idx   <= '0;
         last  <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= in_data;
         idx   <= in_idx;
         last  <= in_last;
      end else if (accept) begin
         valid <= 1'b0;
      end
   end

endmodule : stream_hold_reg

// File: rtl/regfile_dump_reader.sv
// Sequential register-file dump reader. On start it borrows one regfile read
// port, reads indices FIRST_REG..LAST_REG in ascending order and streams each
// value with its index on a valid/ready interface. Read-only.
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   start                 dump request, sampled only while idle
//   portReq / portGrant   read-port ownership handshake with the datapath
//   rdReg / rdData        regfile read address and combinational read data
//   outValid / outReady   stream handshake
//   outData / outIdx      register value and its index
//   outLast               marks the LAST_REG beat
//   busy                  high whenever a dump is in progress
//   done                  one-cycle pulse after the last beat is accepted
module regfile_dump_reader
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W    = REG_DATA_W,
   parameter int unsigned ADDR_W    = REG_ADDR_W,
   parameter int unsigned FIRST_REG = 0,
   parameter int unsigned LAST_REG  = NUM_REGS - 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              portReq,
   input  logic              portGrant,
   output logic [ADDR_W-1:0] rdReg,
   input  logic [DATA_W-1:0] rdData,
   output logic              outValid,
   input  logic              outReady,
   output logic [DATA_W-1:0] outData,
   output logic [ADDR_W-1:0] outIdx,
   output logic              outLast,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

   dump_state_t       state;
   dump_state_t       state_n;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] idx_n;
   logic              load;
   logic              accept;
   logic              idx_is_last;

   assign idx_is_last = (idx == LAST_IDX);

   // Next-state, index and capture decode.
   always_comb begin
      state_n = state;
      idx_n   = idx;
      load    = 1'b0;
      accept  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_n = REQ;
               idx_n   = FIRST_IDX;
            end
         end
         REQ: begin
            if (portGrant) begin
               state_n = READ;
            end
         end
         READ: begin
            // Grant loss sends us back to REQ without touching idx, so the
            // same register is re-read once the port is returned.
            if (portGrant) begin
               load    = 1'b1;
               state_n = SEND;
            end else begin
               state_n = REQ;
            end
         end
         SEND: begin
            accept = outValid && outReady;
            if (accept) begin
               // Terminal check precedes the increment, so idx never wraps.
               if (outLast) begin
                  state_n = DONE;
               end else begin
                  idx_n   = idx + ADDR_W'(1);
                  state_n = REQ;
               end
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State, index and registered control outputs, all decoded from next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         idx     <= FIRST_IDX;
         portReq <= 1'b0;
         rdReg   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         idx     <= idx_n;
         portReq <= (state_n == REQ) || (state_n == READ);
         busy    <= (state_n != IDLE);
         done    <= (state_n == DONE);
         // Address is presented for the whole READ cycle so the combinational
         // rdData is valid at the capture edge.
         if (state_n == READ) begin
            rdReg <= idx_n;
         end
      end
   end

   // Output beat register; outValid comes straight from a flop.
   stream_hold_reg #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_hold (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .accept  (accept),
      .in_data (rdData),
      .in_idx  (idx),
      .in_last (idx_is_last),
      .valid   (outValid),
      .data    (outData),
      .idx     (outIdx),
      .last    (outLast)
   );

endmodule : regfile_dump_reader

// File: tb/tb_regfile_dump_reader.sv
// Directed self-checking bench for regfile_dump_reader: full dump, backpressure,
// ignored start, grant loss, async reset mid-dump and a 4..6 range instance.
module tb_regfile_dump_reader;

   logic        clk = 1'b0;
   logic        reset;

   // Full-range instance
   logic        start;
   logic        port_req;
   logic        port_grant;
   logic [4:0]  rd_reg;
   logic [63:0] rd_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [4:0]  out_idx;
   logic        out_last;
   logic        busy;
   logic        done;

   // Range 4..6 instance
   logic        start2;
   logic        port_req2;
   logic        port_grant2;
   logic [4:0]  rd_reg2;
   logic [63:0] rd_data2;
   logic        out_valid2;
   logic        out_ready2;
   logic [63:0] out_data2;
   logic [4:0]  out_idx2;
   logic        out_last2;
   logic        busy2;
   logic        done2;

   logic [63:0] regs [32];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Register-file model: combinational read, X31 hardwired to zero.
   always_comb rd_data  = regs[rd_reg];
   always_comb rd_data2 = regs[rd_reg2];

   regfile_dump_reader dut (
      .clk(clk), .reset(reset), .start(start),
      .portReq(port_req), .portGrant(port_grant),
      .rdReg(rd_reg), .rdData(rd_data),
      .outValid(out_valid), .outReady(out_ready),
      .outData(out_data), .outIdx(out_idx), .outLast(out_last),
      .busy(busy), .done(done)
   );

   regfile_dump_reader #(.FIRST_REG(4), .LAST_REG(6)) dut2 (
      .clk(clk), .reset(reset), .start(start2),
      .portReq(port_req2), .portGrant(port_grant2),
      .rdReg(rd_reg2), .rdData(rd_data2),
      .outValid(out_valid2), .outReady(out_ready2),
      .outData(out_data2), .outIdx(out_idx2), .outLast(out_last2),
      .busy(busy2), .done(done2)
   );

   function automatic logic [63:0] exp_data(input int i);
      if (i == 31) return 64'h0;
      return 64'(i) * 64'h0000010204080001;
   endfunction

   task automatic wr(input int a, input logic [63:0] v);
      if (a != 31) regs[a] = v;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for an accepted beat on instance sel, return its payload.
   task automatic collect(input bit sel, output logic [4:0] bidx,
                          output logic [63:0] bdata, output logic blast,
                          output int bcyc);
      bit got;
      got   = 1'b0;
      bidx  = '0;
      bdata = '0;
      blast = 1'b0;
      bcyc  = 0;
      for (int n = 0; n < 200 && !got; n++) begin
         if (sel ? (out_valid2 && out_ready2) : (out_valid && out_ready)) begin
            bidx  = sel ? out_idx2  : out_idx;
            bdata = sel ? out_data2 : out_data;
            blast = sel ? out_last2 : out_last;
            bcyc  = cyc;
            got   = 1'b1;
         end
         step();
      end
      checks++;
      assert (got) else begin
         errors++;
         $error("FAIL beat_timeout observed=none expected=beat");
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic check_beat(input int i, input logic [4:0] bidx,
                             input logic [63:0] bdata, input logic blast);
      chk($sformatf("idx_%0d", i), 64'(bidx), 64'(i));
      chk($sformatf("data_%0d", i), bdata, exp_data(i));
      chk($sformatf("last_%0d", i), 64'(blast), 64'(i == 31));
   endtask

   initial begin
      logic [4:0]  bidx;
      logic [63:0] bdata;
      logic        blast;
      int          bcyc;
      int          prev_cyc;
      bit          seen;

      reset = 1'b1;
      start = 1'b0;  port_grant = 1'b1;  out_ready = 1'b1;
      start2 = 1'b0; port_grant2 = 1'b1; out_ready2 = 1'b1;
      for (int i = 0; i < 32; i++) regs[i] = 64'h0;
      for (int i = 0; i < 31; i++) wr(i, exp_data(i));
      wr(31, 64'hA0);
      prev_cyc = 0;

      // Reset state
      step();
      chk("rst_valid", 64'(out_valid), 64'h0);
      chk("rst_data", out_data, 64'h0);
      chk("rst_idx", 64'(out_idx), 64'h0);
      chk("rst_last", 64'(out_last), 64'h0);
      chk("rst_portreq", 64'(port_req), 64'h0);
      chk("rst_rdreg", 64'(rd_reg), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_done", 64'(done), 64'h0);
      #3 reset = 1'b0;
      step();
      chk("idle_busy", 64'(busy), 64'h0);

      // Normal dump with grant and ready held high
      pulse_start();
      chk("start_busy", 64'(busy), 64'h1);
      for (int i = 0; i < 32; i++) begin
         collect(1'b0, bidx, bdata, blast, bcyc);
         check_beat(i, bidx, bdata, blast);
         if (i == 30) chk("x30_const", bdata, 64'h00001E3C78F0001E);
         if (i == 2) chk("beat_spacing", 64'(bcyc - prev_cyc), 64'd3);
         prev_cyc = bcyc;
      end
      chk("done_pulse", 64'(done), 64'h1);
      chk("done_busy", 64'(busy), 64'h1);
      step();
      chk("done_clear", 64'(done), 64'h0);
      chk("busy_fall", 64'(busy), 64'h0);
      chk("idle_valid", 64'(out_valid), 64'h0);

      // Backpressure at idx 5 plus an ignored start while at idx 3
      pulse_start();
      for (int i = 0; i < 32; i++) begin
         if (i == 5) begin
            out_ready = 1'b0;
            seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
               if (out_valid) seen = 1'b1;
               else step();
            end
            chk("bp_reach", 64'(seen), 64'h1);
            for (int n = 0; n < 10; n++) begin
               chk("bp_valid", 64'(out_valid), 64'h1);
               chk("bp_data", out_data, 64'h0000050A14280005);
               chk("bp_idx", 64'(out_idx), 64'd5);
               step();
            end
            out_ready = 1'b1;
         end
         collect(1'b0, bidx, bdata, blast, bcyc);
         check_beat(i, bidx, bdata, blast);
         if (i == 3) begin
            chk("busy_at_3", 64'(busy), 64'h1);
            pulse_start();
         end
      end
      chk("bp_done", 64'(done), 64'h1);
      step();

      // Grant loss during READ of idx 12
      pulse_start();
      for (int i = 0; i < 32; i++) begin
         if (i == 12) begin
            seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
               if (port_req && rd_reg == 5'd12 && !out_valid) seen = 1'b1;
               else step();
            end
            chk("gl_read12", 64'(seen), 64'h1);
            port_grant = 1'b0;
            for (int n = 0; n < 4; n++) begin
               step();
               chk("gl_novalid", 64'(out_valid), 64'h0);
               chk("gl_portreq", 64'(port_req), 64'h1);
            end
            port_grant = 1'b1;
         end
         collect(1'b0, bidx, bdata, blast, bcyc);
         check_beat(i, bidx, bdata, blast);
      end
      chk("gl_done", 64'(done), 64'h1);
      step();
      for (int n = 0; n < 5; n++) begin
         chk("gl_no_extra", 64'(out_valid), 64'h0);
         step();
      end

      // Async reset while SEND at idx 7
      pulse_start();
      for (int i = 0; i < 7; i++) begin
         collect(1'b0, bidx, bdata, blast, bcyc);
         check_beat(i, bidx, bdata, blast);
      end
      out_ready = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         if (out_valid) seen = 1'b1;
         else step();
      end
      chk("ar_send7", 64'(out_idx), 64'd7);
      #2 reset = 1'b1;
      #1;
      chk("ar_valid", 64'(out_valid), 64'h0);
      chk("ar_data", out_data, 64'h0);
      chk("ar_idx", 64'(out_idx), 64'h0);
      chk("ar_last", 64'(out_last), 64'h0);
      chk("ar_portreq", 64'(port_req), 64'h0);
      chk("ar_rdreg", 64'(rd_reg), 64'h0);
      chk("ar_busy", 64'(busy), 64'h0);
      chk("ar_done", 64'(done), 64'h0);
      step();
      #3 reset = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 3; n++) begin
         step();
         chk("ar_nodone", 64'(done), 64'h0);
         chk("ar_idle", 64'(busy), 64'h0);
      end
      pulse_start();
      for (int i = 0; i < 32; i++) begin
         collect(1'b0, bidx, bdata, blast, bcyc);
         check_beat(i, bidx, bdata, blast);
      end
      chk("ar_redump_done", 64'(done), 64'h1);
      step();

      // Range 4..6 instance
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         collect(1'b1, bidx, bdata, blast, bcyc);
         chk($sformatf("v_idx_%0d", k), 64'(bidx), 64'(4 + k));
         chk($sformatf("v_data_%0d", k), bdata, exp_data(4 + k));
         chk($sformatf("v_last_%0d", k), 64'(blast), 64'(k == 2));
      end
      chk("v_done", 64'(done2), 64'h1);
      step();
      chk("v_busy_fall", 64'(busy2), 64'h0);
      for (int n = 0; n < 6; n++) begin
         chk("v_no_extra", 64'(out_valid2), 64'h0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_regfile_dump_reader
